button_debounce: RTL and testbench

- Front-end conditioning stage for the four direction pushbuttons. Feeds the game stage's right_deb/left_deb/up_deb/down_deb inputs.
- Synchronises the raw asynchronous buttons into the vgaclk domain and rejects bounce with a per-button stability counter.
- Emits at most one single-cycle move pulse per clock, so the game state machine never sees two moves in the same cycle.

---
 rtl/game_pkg.sv | 16 +
 rtl/debounce_chan.sv | 87 ++++++++
 rtl/button_debounce.sv | 71 +++++++
 tb/tb_button_debounce.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared debounce state encoding, button indices and default timing constants
package game_pkg;

    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} deb_state_t;

    localparam int BTN_RIGHT = 3;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_UP    = 1;
    localparam int BTN_DOWN  = 0;

    localparam int DEF_STABLE_CYCLES = 250000;
    localparam int DEF_CNT_W         = 18;
    localparam int DEF_REPEAT_DELAY  = 12500000;
    localparam int DEF_REPEAT_PERIOD = 3750000;

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: 2-flop synchroniser, stability FSM and one-cycle press request (auto-repeat under DEBOUNCE_AUTOREPEAT_EN)
module debounce_chan
    import game_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic vgaclk,
    input  logic reset,
    input  logic btn,
    output logic held,
    output logic req
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync;
    logic             s;
    logic             done;
    logic             press;
    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    assign s    = sync[1];
    assign done = cnt == CNT_MAX;
    assign held = state == HELD || state == RELEASING;

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // cnt_n defaults to zero so every state entry starts a fresh count; it stops at CNT_MAX because done forces a transition
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        press   = 1'b0;
        case (state)
            IDLE:      state_n = s ? ARMING : IDLE;
            ARMING: begin
                if (!s) state_n = IDLE;
                else if (done) begin
                    state_n = HELD;
                    press   = 1'b1;
                end else cnt_n = cnt + 1'b1;
            end
            HELD:      state_n = s ? HELD : RELEASING;
            RELEASING: begin
                if (s) state_n = HELD;
                else if (done) state_n = IDLE;
                else cnt_n = cnt + 1'b1;
            end
        endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

    logic [RPT_W-1:0] rcnt;
    logic             rpt;

    assign rpt = held && rcnt == RPT_W'(REPEAT_DELAY - 1);

    // after each repeat, reload so the next one lands REPEAT_PERIOD cycles later
    always_ff @(posedge vgaclk) begin
        if (reset || !held) rcnt <= '0;
        else rcnt <= rpt ? RPT_W'(REPEAT_DELAY - REPEAT_PERIOD) : rcnt + 1'b1;
    end

    assign req = press | rpt;
`else
    assign req = press;
`endif

endmodule

// File: rtl/button_debounce.sv
// button_debounce: four debounced direction buttons with a fixed-priority one-hot move pulse arbiter (auto-repeat under DEBOUNCE_AUTOREPEAT_EN)
module button_debounce
    import game_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       vgaclk,
    input  logic       reset,
    input  logic       right_btn,
    input  logic       left_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    output logic       right_deb,
    output logic       left_deb,
    output logic       up_deb,
    output logic       down_deb,
    output logic [3:0] btn_held
);

    if (STABLE_CYCLES < 1 || 2 ** CNT_W <= STABLE_CYCLES || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("button_debounce: invalid timing parameters");
    end

    logic [3:0] raw, req, pend, eff, grant, deb;

    assign raw = {right_btn, left_btn, up_btn, down_btn};

    for (genvar i = 0; i < 4; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_chan (
            .vgaclk(vgaclk),
            .reset (reset),
            .btn   (raw[i]),
            .held  (btn_held[i]),
            .req   (req[i])
        );
    end

    // fresh requests join the pending set so a same-cycle request is served without a wait cycle
    assign eff = pend | req;

    always_comb begin
        grant = eff[BTN_RIGHT] ? 4'b1000 :
                eff[BTN_LEFT]  ? 4'b0100 :
                eff[BTN_UP]    ? 4'b0010 :
                eff[BTN_DOWN]  ? 4'b0001 : 4'b0000;
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            pend <= '0;
            deb  <= '0;
        end else begin
            pend <= eff & ~grant;
            deb  <= grant;
        end
    end

    assign {right_deb, left_deb, up_deb, down_deb} = deb;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: table vectors, corner sequences and random stimulus against a streak-counting reference model
module tb_button_debounce;

    localparam int S = 4;
    localparam int D = 20;
    localparam int P = 6;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] deb;
        logic [3:0] held;
    } vec_t;

    logic       vgaclk = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] btns   = '0;
    logic       right_deb, left_deb, up_deb, down_deb;
    logic [3:0] btn_held;
    logic [3:0] deb;

    int errors = 0;
    int checks = 0;

    logic [3:0] m1 = '0, m2 = '0, lvl = '0, pend = '0, exp_deb = '0;
    int streak[4];
    int age[4];

    vec_t tbl[24];

    assign deb = {right_deb, left_deb, up_deb, down_deb};

    button_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (3),
        .REPEAT_DELAY (D),
        .REPEAT_PERIOD(P)
    ) dut (
        .vgaclk   (vgaclk),
        .reset    (reset),
        .right_btn(btns[3]),
        .left_btn (btns[2]),
        .up_btn   (btns[1]),
        .down_btn (btns[0]),
        .right_deb(right_deb),
        .left_deb (left_deb),
        .up_deb   (up_deb),
        .down_deb (down_deb),
        .btn_held (btn_held)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // a button's level flips after S+1 consecutive synchronised samples disagreeing with it; a rise requests a move
    task automatic model_edge(input logic r, input logic [3:0] b);
        logic [3:0] s, req, eff, g;
        if (r) begin
            m1 = '0; m2 = '0; lvl = '0; pend = '0; exp_deb = '0;
            for (int i = 0; i < 4; i++) begin
                streak[i] = 0;
                age[i]    = 0;
            end
        end else begin
            s  = m2;
            m2 = m1;
            m1 = b;
            req = '0;
            for (int i = 0; i < 4; i++) begin
                if (lvl[i]) begin
                    age[i]++;
                    if (AR && age[i] >= D && (age[i] - D) % P == 0) req[i] = 1'b1;
                end
                if (s[i] != lvl[i]) begin
                    streak[i]++;
                    if (streak[i] == S + 1) begin
                        lvl[i]    = ~lvl[i];
                        streak[i] = 0;
                        age[i]    = 0;
                        if (lvl[i]) req[i] = 1'b1;
                    end
                end else streak[i] = 0;
            end
            eff = pend | req;
            g   = '0;
            for (int i = 0; i < 4; i++) if (eff[i]) g = 4'(1 << i);
            exp_deb = g;
            pend    = eff & ~g;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] b);
        @(negedge vgaclk);
        reset = r;
        btns  = b;
        @(posedge vgaclk);
        model_edge(r, b);
        #1;
        check("model_deb", deb, exp_deb);
        check("model_held", btn_held, lvl);
        checks++;
        if ($countones(deb) > 1) begin
            errors++;
            $display("FAIL onehot: deb=%b at %0t", deb, $time);
        end
    endtask

    initial begin
        int np, np_early;
        logic [3:0] cur;

        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 10; k++)
            tbl[1 + k] = '{1'b0, 4'b1000, (k == 6) ? 4'b1000 : 4'b0000, (k >= 6) ? 4'b1000 : 4'b0000};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        for (int k = 0; k < 12; k++)
            tbl[12 + k] = '{1'b0, 4'b1111,
                            (k == 6) ? 4'b1000 : (k == 7) ? 4'b0100 : (k == 8) ? 4'b0010 : (k == 9) ? 4'b0001 : 4'b0000,
                            (k >= 6) ? 4'b1111 : 4'b0000};

        for (int k = 0; k < 3; k++) step(1'b1, 4'b1111);
        check("reset_deb", deb, 4'b0000);
        check("reset_held", btn_held, 4'b0000);

        for (int j = 0; j < 24; j++) begin
            step(tbl[j].rst, tbl[j].raw);
            check("tbl_deb", deb, tbl[j].deb);
            check("tbl_held", btn_held, tbl[j].held);
        end

        // bounce on up: toggling never qualifies, steady level qualifies once
        step(1'b1, 4'b0000);
        np = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k % 4 < 2) ? 4'b0010 : 4'b0000);
            np += int'(up_deb);
        end
        check_int("bounce_quiet", np, 0);
        for (int k = 20; k < 30; k++) begin
            step(1'b0, 4'b0010);
            np += int'(up_deb);
            if (k == 26) check("bounce_pulse", deb, 4'b0010);
        end
        check_int("bounce_count", np, 1);

        // short release glitch on left while held
        step(1'b1, 4'b0000);
        np = 0;
        for (int k = 0; k < 24; k++) begin
            step(1'b0, (k == 12 || k == 13) ? 4'b0000 : 4'b0100);
            np += int'(left_deb);
        end
        check_int("glitch_count", np, 1);
        check("glitch_held", btn_held, 4'b0100);

        // reset while down is arming, button kept held
        step(1'b1, 4'b0000);
        np = 0;
        np_early = 0;
        for (int k = 0; k < 15; k++) begin
            step(k == 3, 4'b0001);
            np += int'(down_deb);
            if (k < 10) np_early += int'(down_deb);
            if (k == 10) check("rst_arm_pulse", deb, 4'b0001);
        end
        check_int("rst_arm_early", np_early, 0);
        check_int("rst_arm_count", np, 1);

        // long hold on right
        step(1'b1, 4'b0000);
        np = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 4'b1000);
            np += int'(right_deb);
            if (k == 26 || k == 32 || k == 38 || k == 44)
                check("repeat_pulse", deb, AR ? 4'b1000 : 4'b0000);
        end
        check_int("repeat_count", np, AR ? 5 : 1);

        step(1'b1, 4'b0000);
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) cur[i] = ~cur[i];
            step($urandom_range(0, 399) == 0, cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
